uart_param_txrx: RTL and testbench
==================================

UART_PARAM_TXRX -- requirements
Module: uart_param_txrx

Interface
REQ-001 SHALL provide parameter DATA_BITS, default 8, data bits per frame, legal 5..9.
REQ-002 SHALL provide parameter PARITY, default 0, 0=none 1=odd 2=even.
REQ-003 SHALL provide parameter STOP_BITS, default 1, stop bits on TX, legal 1..2.
REQ-004 SHALL provide parameter OVERSAMPLE, default 16, ticks per bit, power of 2, minimum 8.
REQ-005 SHALL provide parameter DIV_WIDTH, default 16, width of baud_div.
REQ-006 SHALL have one clock and an asynchronous active-high reset: clk input 1 system clock; rst input 1 asynchronous active-high reset.
REQ-007 SHALL have port baud_div, input, DIV_WIDTH bits: clk cycles per oversample tick minus 1; values 0 and 1 are illegal.
REQ-008 SHALL have port tx_valid, input, 1 bit: TX byte offered.
REQ-009 SHALL have port tx_data, input, DATA_BITS bits: TX payload, LSB first on the line.
REQ-010 SHALL have port tx_ready, output, 1 bit: transmitter accepts on tx_valid&tx_ready.
REQ-011 SHALL have port txd, output, 1 bit: serial out, idle high.
REQ-012 SHALL have port rxd, input, 1 bit: asynchronous serial in.
REQ-013 SHALL have port rx_valid, output, 1 bit: one-cycle strobe, frame received.
REQ-014 SHALL have port rx_data, output, DATA_BITS bits: received payload, held until the next strobe.
REQ-015 SHALL have port rx_parity_err, output, 1 bit: qualified by rx_valid; always 0 when PARITY=0.
REQ-016 SHALL have port rx_frame_err, output, 1 bit: qualified by rx_valid; stop bit sampled low.

Function
REQ-017 SHALL use one free-running tick counter that reloads at baud_div, emits a one-cycle tick per reload, and is shared by TX and RX; a baud_div change takes effect at the next reload.
REQ-018 SHALL latch tx_data on the handshake; tx_ready drops the following cycle and tx_data may then change freely.
REQ-019 TX FSM SHALL run IDLE -> START -> DATA (DATA_BITS bits) -> PARITY (only if PARITY!=0) -> STOP (STOP_BITS bits) -> IDLE; each bit lasts exactly OVERSAMPLE ticks.
REQ-020 SHALL register txd (glitch-free): START drives 0; PARITY drives the XOR of the data bits for even parity, its inverse for odd.
REQ-021 tx_ready SHALL rise in the cycle the last stop bit ends; back-to-back handshakes produce frames with no idle gap.
REQ-022 SHALL pass rxd through a 2-flop synchroniser reset to 1 before any use.
REQ-023 RX FSM SHALL run IDLE -> START -> DATA -> PARITY (if enabled) -> STOP -> IDLE and leave IDLE on a synchronised falling edge.
REQ-024 RX SHALL resample the line OVERSAMPLE/2 ticks after the falling edge; if the line is high, the start is false and RX SHALL return to IDLE with no strobe.
REQ-025 RX SHALL sample each later bit at its centre, every OVERSAMPLE ticks, assembling data LSB first.
REQ-026 SHALL pulse rx_valid for one clk at the stop-bit sample, together with updated rx_data, rx_parity_err and rx_frame_err; RX checks one stop bit only and re-arms for a start edge immediately.
REQ-027 On a frame error with all data bits 0 (break), RX SHALL wait for rxd high before re-arming.
REQ-028 TX and RX SHALL operate fully independently; rxd tied to txd SHALL loop back without error.

Reset
REQ-029 While rst=1: txd=1, tx_ready=1, rx_valid=0, rx_data=0, both error flags 0, both FSMs in IDLE, tick counter 0, synchroniser 2'b11.
REQ-030 rst asserted mid-frame SHALL abort both directions at once; no strobe is produced, and after release tx_ready=1 in the first cycle.

Verification
REQ-031 Loopback, DATA_BITS=8, PARITY=0, baud_div=4, OVERSAMPLE=16: send 0xA5 -> rx_valid once, rx_data=0xA5, no errors, frame length 10*16*5=800 clk.
REQ-032 PARITY=2: send 0x07 -> txd parity bit 1; a corrupted parity bit injected on rxd -> rx_parity_err=1, rx_data=0x07.
REQ-033 rxd low pulse of 3 ticks -> no rx_valid; RX back in IDLE and the next valid frame 0x3C is received correctly.
REQ-034 STOP_BITS=2, back-to-back 0x00 then 0xFF -> exactly 11 bit-times per frame (with parity off), tx_ready high 1 cycle between frames.
REQ-035 rxd held low 20 bit-times -> single rx_valid with rx_frame_err=1 and rx_data=0, no further strobe until rxd returns high.
REQ-036 rst pulse halfway through TX byte 0x55 -> txd=1 within the same cycle, tx_ready=1 after release, no rx_valid on the loopback.

Source files
------------

// File: rtl/uart_param_txrx.sv
`timescale 1ns/1ps
// Parameterised UART transmitter/receiver sharing one oversample tick generator.
// Latency: TX line starts the cycle after the handshake; rx_valid strobes at the stop-bit centre sample.
// Backpressure: tx_ready is low for a whole frame; RX has no backpressure (strobe + held data).
module uart_param_txrx #(
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int OVERSAMPLE = 16,
  parameter int DIV_WIDTH  = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [DIV_WIDTH-1:0] baud_div,
  input  logic                 tx_valid,
  input  logic [DATA_BITS-1:0] tx_data,
  output logic                 tx_ready,
  output logic                 txd,
  input  logic                 rxd,
  output logic                 rx_valid,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_parity_err,
  output logic                 rx_frame_err
);

  localparam int             OSW       = $clog2(OVERSAMPLE);
  localparam logic [OSW-1:0] OS_LAST   = OSW'(OVERSAMPLE - 1);
  localparam logic [OSW-1:0] OS_MID    = OSW'(OVERSAMPLE / 2 - 1);
  localparam int             BW        = 4;
  localparam logic [BW-1:0]  DATA_LAST = BW'(DATA_BITS - 1);
  localparam logic [BW-1:0]  STOP_LAST = BW'(STOP_BITS - 1);
  localparam logic           PAR_ODD   = (PARITY == 1);
  localparam logic           PAR_EN    = (PARITY != 0);

  // ---------------------------------------------------------------------
  // Shared oversample tick: down-counter that reloads from baud_div, so a
  // new divisor is only picked up at the next reload.
  // ---------------------------------------------------------------------
  logic [DIV_WIDTH-1:0] cnt_q, cnt_d;
  logic                 tick;

  // Next-state of the tick counter; tick fires in the cycle the count is zero.
  always_comb begin
    tick  = (cnt_q == '0);
    cnt_d = tick ? baud_div : cnt_q - DIV_WIDTH'(1);
  end

  // Tick counter register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  // ---------------------------------------------------------------------
  // Transmitter
  // ---------------------------------------------------------------------
  typedef enum logic [2:0] {TX_IDLE, TX_START, TX_DATA, TX_PAR, TX_STOP} tx_state_t;

  tx_state_t            tx_st_q;
  logic [OSW-1:0]       tx_os_q;
  logic [BW-1:0]        tx_bit_q;
  logic [DATA_BITS-1:0] tx_sh_q;
  logic                 tx_par_q;
  logic                 txd_q;
  logic                 tx_rdy_q;

  // TX FSM: latch on handshake, then each line bit is held for OVERSAMPLE ticks.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_st_q  <= TX_IDLE;
      tx_os_q  <= '0;
      tx_bit_q <= '0;
      tx_sh_q  <= '0;
      tx_par_q <= 1'b0;
      txd_q    <= 1'b1;
      tx_rdy_q <= 1'b1;
    end else if (tx_st_q == TX_IDLE) begin
      if (tx_valid) begin
        tx_sh_q  <= tx_data;
        tx_par_q <= (^tx_data) ^ PAR_ODD;
        tx_rdy_q <= 1'b0;
        txd_q    <= 1'b0;
        tx_os_q  <= '0;
        tx_st_q  <= TX_START;
      end
    end else if (tick) begin
      if (tx_os_q != OS_LAST) begin
        tx_os_q <= tx_os_q + 1'b1;
      end else begin
        tx_os_q <= '0;
        case (tx_st_q)
          TX_START: begin
            tx_st_q  <= TX_DATA;
            tx_bit_q <= '0;
            txd_q    <= tx_sh_q[0];
          end
          TX_DATA: begin
            if (tx_bit_q == DATA_LAST) begin
              tx_bit_q <= '0;
              if (PAR_EN) begin
                tx_st_q <= TX_PAR;
                txd_q   <= tx_par_q;
              end else begin
                tx_st_q <= TX_STOP;
                txd_q   <= 1'b1;
              end
            end else begin
              tx_bit_q <= tx_bit_q + 1'b1;
              txd_q    <= tx_sh_q[1];
              tx_sh_q  <= tx_sh_q >> 1;
            end
          end
          TX_PAR: begin
            tx_st_q  <= TX_STOP;
            tx_bit_q <= '0;
            txd_q    <= 1'b1;
          end
          TX_STOP: begin
            // Ready rises as the last stop bit ends so a waiting byte starts with no gap.
            if (tx_bit_q == STOP_LAST) begin
              tx_st_q  <= TX_IDLE;
              tx_rdy_q <= 1'b1;
            end else begin
              tx_bit_q <= tx_bit_q + 1'b1;
            end
          end
          default: tx_st_q <= TX_IDLE;
        endcase
      end
    end
  end

  assign tx_ready = tx_rdy_q;
  assign txd      = txd_q;

  // ---------------------------------------------------------------------
  // Receiver
  // ---------------------------------------------------------------------
  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_PAR, RX_STOP, RX_BRK} rx_state_t;

  logic [1:0]           sync_q;
  logic                 rx_prev_q;
  logic                 rxs;
  rx_state_t            rx_st_q;
  logic [OSW-1:0]       rx_os_q;
  logic [BW-1:0]        rx_bit_q;
  logic [DATA_BITS-1:0] rx_sh_q;
  logic                 rx_par_q;
  logic                 rx_perr_q;
  logic                 rx_valid_q;
  logic [DATA_BITS-1:0] rx_data_q;
  logic                 rx_perr_out_q;
  logic                 rx_ferr_q;

  assign rxs = sync_q[1];

  // Two-flop synchroniser plus one delayed copy for falling-edge detection.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q    <= 2'b11;
      rx_prev_q <= 1'b1;
    end else begin
      sync_q    <= {sync_q[0], rxd};
      rx_prev_q <= rxs;
    end
  end

  // RX FSM: start edge, half-bit start check, then centre sampling every OVERSAMPLE ticks.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_st_q       <= RX_IDLE;
      rx_os_q       <= '0;
      rx_bit_q      <= '0;
      rx_sh_q       <= '0;
      rx_par_q      <= 1'b0;
      rx_perr_q     <= 1'b0;
      rx_valid_q    <= 1'b0;
      rx_data_q     <= '0;
      rx_perr_out_q <= 1'b0;
      rx_ferr_q     <= 1'b0;
    end else begin
      rx_valid_q <= 1'b0;
      case (rx_st_q)
        RX_IDLE: begin
          if (rx_prev_q && !rxs) begin
            rx_st_q <= RX_START;
            rx_os_q <= '0;
          end
        end
        RX_BRK: begin
          // A break holds the line low; only re-arm once it has gone idle again.
          if (rxs) rx_st_q <= RX_IDLE;
        end
        RX_START: begin
          if (tick) begin
            if (rx_os_q != OS_MID) begin
              rx_os_q <= rx_os_q + 1'b1;
            end else begin
              rx_os_q <= '0;
              if (rxs) begin
                rx_st_q <= RX_IDLE;
              end else begin
                rx_st_q   <= RX_DATA;
                rx_bit_q  <= '0;
                rx_par_q  <= 1'b0;
                rx_perr_q <= 1'b0;
              end
            end
          end
        end
        default: begin
          if (tick) begin
            if (rx_os_q != OS_LAST) begin
              rx_os_q <= rx_os_q + 1'b1;
            end else begin
              rx_os_q <= '0;
              case (rx_st_q)
                RX_DATA: begin
                  rx_sh_q  <= {rxs, rx_sh_q[DATA_BITS-1:1]};
                  rx_par_q <= rx_par_q ^ rxs;
                  if (rx_bit_q == DATA_LAST) rx_st_q <= PAR_EN ? RX_PAR : RX_STOP;
                  else                       rx_bit_q <= rx_bit_q + 1'b1;
                end
                RX_PAR: begin
                  rx_perr_q <= (rxs != (rx_par_q ^ PAR_ODD));
                  rx_st_q   <= RX_STOP;
                end
                RX_STOP: begin
                  rx_valid_q    <= 1'b1;
                  rx_data_q     <= rx_sh_q;
                  rx_perr_out_q <= rx_perr_q;
                  rx_ferr_q     <= !rxs;
                  rx_st_q       <= (!rxs && (rx_sh_q == '0)) ? RX_BRK : RX_IDLE;
                end
                default: rx_st_q <= RX_IDLE;
              endcase
            end
          end
        end
      endcase
    end
  end

  assign rx_valid      = rx_valid_q;
  assign rx_data       = rx_data_q;
  assign rx_parity_err = rx_perr_out_q;
  assign rx_frame_err  = rx_ferr_q;

endmodule

// File: tb/tb_uart_param_txrx.sv
`timescale 1ns/1ps
// Scoreboard bench for uart_param_txrx: three instances (plain 8N1, even parity, two stop bits).
// Stimulus pushes expected RX frames into per-instance queues; monitors pop on rx_valid.
// TX timing is measured in clk cycles against hand-computed bit-time windows.
module tb_uart_param_txrx;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [15:0] baud_div;

  logic       tx_valid_w [3];
  logic [7:0] tx_data_w  [3];
  logic       tx_ready_w [3];
  logic       txd_w      [3];
  logic       rxd_w      [3];
  logic       rx_valid_w [3];
  logic [7:0] rx_data_w  [3];
  logic       perr_w     [3];
  logic       ferr_w     [3];
  logic       loop_w     [3];
  logic       drv_w      [3];

  always_comb begin
    for (int i = 0; i < 3; i++) rxd_w[i] = loop_w[i] ? txd_w[i] : drv_w[i];
  end

  uart_param_txrx #(.DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .OVERSAMPLE(16), .DIV_WIDTH(16)) u_a (
    .clk(clk), .rst(rst), .baud_div(baud_div),
    .tx_valid(tx_valid_w[0]), .tx_data(tx_data_w[0]), .tx_ready(tx_ready_w[0]), .txd(txd_w[0]),
    .rxd(rxd_w[0]), .rx_valid(rx_valid_w[0]), .rx_data(rx_data_w[0]),
    .rx_parity_err(perr_w[0]), .rx_frame_err(ferr_w[0]));

  uart_param_txrx #(.DATA_BITS(8), .PARITY(2), .STOP_BITS(1), .OVERSAMPLE(16), .DIV_WIDTH(16)) u_b (
    .clk(clk), .rst(rst), .baud_div(baud_div),
    .tx_valid(tx_valid_w[1]), .tx_data(tx_data_w[1]), .tx_ready(tx_ready_w[1]), .txd(txd_w[1]),
    .rxd(rxd_w[1]), .rx_valid(rx_valid_w[1]), .rx_data(rx_data_w[1]),
    .rx_parity_err(perr_w[1]), .rx_frame_err(ferr_w[1]));

  uart_param_txrx #(.DATA_BITS(8), .PARITY(0), .STOP_BITS(2), .OVERSAMPLE(16), .DIV_WIDTH(16)) u_c (
    .clk(clk), .rst(rst), .baud_div(baud_div),
    .tx_valid(tx_valid_w[2]), .tx_data(tx_data_w[2]), .tx_ready(tx_ready_w[2]), .txd(txd_w[2]),
    .rxd(rxd_w[2]), .rx_valid(rx_valid_w[2]), .rx_data(rx_data_w[2]),
    .rx_parity_err(perr_w[2]), .rx_frame_err(ferr_w[2]));

  typedef struct packed {
    logic [7:0] d;
    logic       pe;
    logic       fe;
  } exp_t;

  exp_t q_a[$];
  exp_t q_b[$];
  exp_t q_c[$];

  int checks   = 0;
  int failures = 0;

  function automatic exp_t mk(input logic [7:0] d, input logic pe, input logic fe);
    exp_t e;
    e.d  = d;
    e.pe = pe;
    e.fe = fe;
    return e;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    end
  endtask

  task automatic chk_rng(input string nm, input int act, input int lo, input int hi);
    checks++;
    if (act < lo || act > hi) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d..%0d", nm, act, lo, hi);
    end
  endtask

  task automatic cmp_rx(input string nm, input exp_t e, input int i);
    chk({nm, " data"},   32'(rx_data_w[i]), 32'(e.d));
    chk({nm, " parerr"}, 32'(perr_w[i]),    32'(e.pe));
    chk({nm, " frmerr"}, 32'(ferr_w[i]),    32'(e.fe));
  endtask

  task automatic unexpected(input string nm, input int i);
    checks++;
    failures++;
    $display("FAIL %s unexpected rx_valid actual_data=%0h required=no strobe", nm, rx_data_w[i]);
  endtask

  // Monitors: every strobe must match the oldest outstanding expectation.
  always @(negedge clk) if (!rst && rx_valid_w[0]) begin
    if (q_a.size() == 0) unexpected("rx_a", 0); else cmp_rx("rx_a", q_a.pop_front(), 0);
  end
  always @(negedge clk) if (!rst && rx_valid_w[1]) begin
    if (q_b.size() == 0) unexpected("rx_b", 1); else cmp_rx("rx_b", q_b.pop_front(), 1);
  end
  always @(negedge clk) if (!rst && rx_valid_w[2]) begin
    if (q_c.size() == 0) unexpected("rx_c", 2); else cmp_rx("rx_c", q_c.pop_front(), 2);
  end

  // Wait (bounded) for all outstanding expected strobes to be consumed.
  task automatic drain(input string nm);
    int k = 0;
    while ((q_a.size() + q_b.size() + q_c.size()) != 0 && k < 3000) begin
      @(negedge clk);
      k++;
    end
    checks++;
    if ((q_a.size() + q_b.size() + q_c.size()) != 0) begin
      failures++;
      $display("FAIL %s missing strobes actual=%0d required=0", nm, q_a.size() + q_b.size() + q_c.size());
      q_a.delete();
      q_b.delete();
      q_c.delete();
    end
  endtask

  // One TX handshake; len = cycles from handshake edge to the edge raising tx_ready.
  // sv = txd sampled 'samp' cycles after the handshake edge.
  task automatic tx_send(input int i, input logic [7:0] d, input int samp, output int len, output logic sv);
    int n = 0;
    sv = 1'bx;
    @(negedge clk);
    chk($sformatf("tx_ready idle %0d", i), 32'(tx_ready_w[i]), 32'd1);
    tx_data_w[i]  = d;
    tx_valid_w[i] = 1'b1;
    @(posedge clk);
    #1 tx_valid_w[i] = 1'b0;
    tx_data_w[i] = 8'h00;
    do begin
      @(negedge clk);
      n++;
      if (n - 1 == samp) sv = txd_w[i];
    end while (!tx_ready_w[i] && n < 3000);
    len = n - 1;
  endtask

  // Bit-bang nb line bits (LSB first), each 80 clk (16 ticks of 5 clk).
  task automatic bang(input int i, input logic [11:0] bits, input int nb);
    for (int k = 0; k < nb; k++) begin
      drv_w[i] = bits[k];
      repeat (80) @(negedge clk);
    end
    drv_w[i] = 1'b1;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int   len, len2, n, hi;
    logic sv;

    rst      = 1'b1;
    baud_div = 16'd4;
    for (int i = 0; i < 3; i++) begin
      tx_valid_w[i] = 1'b0;
      tx_data_w[i]  = 8'h00;
      loop_w[i]     = 1'b0;
      drv_w[i]      = 1'b1;
    end
    repeat (3) @(negedge clk);

    // Reset state of every instance.
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("rst txd %0d", i),      32'(txd_w[i]),      32'd1);
      chk($sformatf("rst tx_ready %0d", i), 32'(tx_ready_w[i]), 32'd1);
      chk($sformatf("rst rx_valid %0d", i), 32'(rx_valid_w[i]), 32'd0);
      chk($sformatf("rst rx_data %0d", i),  32'(rx_data_w[i]),  32'd0);
      chk($sformatf("rst perr %0d", i),     32'(perr_w[i]),     32'd0);
      chk($sformatf("rst ferr %0d", i),     32'(ferr_w[i]),     32'd0);
    end
    rst = 1'b0;

    // Loopback 0xA5, 8N1: 10 bits * 16 ticks * 5 clk = 800 clk (tick phase gives -4).
    loop_w[0] = 1'b1;
    q_a.push_back(mk(8'hA5, 1'b0, 1'b0));
    tx_send(0, 8'hA5, -1, len, sv);
    chk_rng("a5 frame len", len, 796, 800);
    drain("a5");

    // Even parity 0x07: parity bit = 1, sampled mid parity bit (bit 9).
    loop_w[1] = 1'b1;
    q_b.push_back(mk(8'h07, 1'b0, 1'b0));
    tx_send(1, 8'h07, 760, len, sv);
    chk("par07 txd parity bit", 32'(sv), 32'd1);
    chk_rng("par07 frame len", len, 876, 880);
    drain("par07 loop");

    // Injected frame 0x07 with parity bit wrongly 0.
    loop_w[1] = 1'b0;
    repeat (20) @(negedge clk);
    q_b.push_back(mk(8'h07, 1'b1, 1'b0));
    bang(1, {1'b1, 1'b1, 1'b0, 8'h07, 1'b0}, 11);
    drain("par07 corrupt");

    // 3-tick low glitch must not strobe; the next frame 0x3C must be received.
    loop_w[0] = 1'b0;
    repeat (20) @(negedge clk);
    drv_w[0] = 1'b0;
    repeat (15) @(negedge clk);
    drv_w[0] = 1'b1;
    repeat (200) @(negedge clk);
    q_a.push_back(mk(8'h3C, 1'b0, 1'b0));
    bang(0, {2'b11, 8'h3C, 1'b0}, 10);
    drain("glitch then 3c");

    // Break: 20 bit-times low gives one frame-error strobe with data 0, then nothing until high.
    q_a.push_back(mk(8'h00, 1'b0, 1'b1));
    drv_w[0] = 1'b0;
    repeat (1600) @(negedge clk);
    drv_w[0] = 1'b1;
    repeat (200) @(negedge clk);
    drain("break");
    q_a.push_back(mk(8'h81, 1'b0, 1'b0));
    bang(0, {2'b11, 8'h81, 1'b0}, 10);
    drain("after break 81");

    // Two stop bits, back-to-back 0x00 then 0xFF: 11 bits = 880 clk per frame.
    loop_w[2] = 1'b1;
    q_c.push_back(mk(8'h00, 1'b0, 1'b0));
    q_c.push_back(mk(8'hFF, 1'b0, 1'b0));
    @(negedge clk);
    tx_data_w[2]  = 8'h00;
    tx_valid_w[2] = 1'b1;
    @(posedge clk);
    #1 tx_data_w[2] = 8'hFF;
    n  = 0;
    hi = 0;
    do begin
      @(negedge clk);
      n++;
      if (tx_ready_w[2]) hi++;
    end while (!(hi > 0 && !tx_ready_w[2]) && n < 3000);
    tx_valid_w[2] = 1'b0;
    chk_rng("b2b frame1 len", n - 2, 876, 880);
    chk("b2b ready high cycles", 32'(hi), 32'd1);
    n = 1;
    do begin
      @(negedge clk);
      n++;
    end while (!tx_ready_w[2] && n < 3000);
    chk_rng("b2b frame2 len", n - 1, 876, 880);
    drain("b2b");

    // Reset halfway through 0x55 on loopback: txd high at once, ready after release, no strobe.
    loop_w[0] = 1'b1;
    @(negedge clk);
    tx_data_w[0]  = 8'h55;
    tx_valid_w[0] = 1'b1;
    @(posedge clk);
    #1 tx_valid_w[0] = 1'b0;
    repeat (360) @(negedge clk);
    chk("55 mid txd low", 32'(txd_w[0]), 32'd0);
    #2 rst = 1'b1;
    #1;
    chk("55 rst txd", 32'(txd_w[0]), 32'd1);
    chk("55 rst tx_ready", 32'(tx_ready_w[0]), 32'd1);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("55 post tx_ready", 32'(tx_ready_w[0]), 32'd1);
    chk("55 post txd", 32'(txd_w[0]), 32'd1);
    repeat (1000) @(negedge clk);

    drain("end");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
